// File: rtl/dft_loop_sequencer.sv
// Direct-DFT loop sequencer: per bin k clears the MAC, walks n=0..N-1, drains the MAC, hands off the result.
// Optional: define DFT_SEQ_HALF_SPECTRUM_EN to stop after bin floor(N/2) (real-input symmetry).
module dft_loop_sequencer #(
    parameter int ADDR_W  = 12,
    parameter int MAC_LAT = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ce,
    input  logic              start,
    input  logic [ADDR_W-1:0] sample_num,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] sample_adr,
    output logic [ADDR_W-1:0] twiddle_adr,
    output logic              mac_clear,
    output logic              mac_en,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_k,
    input  logic              res_ready
);

    localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] n_len;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] n_last;
    logic [ADDR_W-1:0] k_end;
    logic [ADDR_W:0]   tw_sum;
    logic [ADDR_W-1:0] tw_next;

    assign n_last = n_len - ADDR_W'(1);

`ifdef DFT_SEQ_HALF_SPECTRUM_EN
    assign k_end = n_len >> 1;
`else
    assign k_end = n_last;
`endif

    // twiddle index n*k mod N kept incrementally; both operands are < N so one subtraction wraps it
    assign tw_sum  = {1'b0, twiddle_adr} + {1'b0, res_k};
    assign tw_next = (tw_sum >= {1'b0, n_len}) ? (twiddle_adr + res_k - n_len)
                                               : (twiddle_adr + res_k);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            n_len       <= '0;
            lat_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            sample_adr  <= '0;
            twiddle_adr <= '0;
            mac_clear   <= 1'b0;
            mac_en      <= 1'b0;
            res_valid   <= 1'b0;
            res_k       <= '0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_len <= sample_num;
                        res_k <= '0;
                        busy  <= 1'b1;
                        if (sample_num == '0) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            err       <= 1'b0;
                            mac_clear <= 1'b1;
                            state     <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    mac_clear   <= 1'b0;
                    mac_en      <= 1'b1;
                    sample_adr  <= '0;
                    twiddle_adr <= '0;
                    state       <= RUN;
                end
                RUN: begin
                    if (sample_adr == n_last) begin
                        mac_en  <= 1'b0;
                        lat_cnt <= '0;
                        state   <= DRAIN;
                    end else begin
                        sample_adr  <= sample_adr + ADDR_W'(1);
                        twiddle_adr <= tw_next;
                    end
                end
                DRAIN: begin
                    if (lat_cnt == LAT_W'(MAC_LAT - 1)) begin
                        res_valid <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                WRITE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (res_k == k_end) begin
                            state <= DONE;
                        end else begin
                            res_k     <= res_k + ADDR_W'(1);
                            mac_clear <= 1'b1;
                            state     <= CLEAR;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dft_loop_sequencer.sv
// Directed bench for dft_loop_sequencer: table of whole transforms plus reset / start-while-busy sequences.
module tb_dft_loop_sequencer;

    localparam int AW  = 12;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          nrst;
    logic          ce;
    logic          start;
    logic          res_ready;
    logic [AW-1:0] sample_num;
    logic          busy, done, err, mac_clear, mac_en, res_valid;
    logic [AW-1:0] sample_adr, twiddle_adr, res_k;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dft_loop_sequencer #(.ADDR_W(AW), .MAC_LAT(LAT)) dut (
        .clk(clk), .nrst(nrst), .ce(ce), .start(start), .sample_num(sample_num),
        .busy(busy), .done(done), .err(err), .sample_adr(sample_adr),
        .twiddle_adr(twiddle_adr), .mac_clear(mac_clear), .mac_en(mac_en),
        .res_valid(res_valid), .res_k(res_k), .res_ready(res_ready)
    );

    typedef struct {
        int n;
        int stall_bin;
        int stall_len;
        bit ce_tog;
        int exp_res;
        int exp_mac;
        int exp_clr;
        int exp_lat;
        int exp_valid;
        bit exp_err;
    } vec_t;

    vec_t vt[6];
    int   tw_k3[8];
    int   r_res, r_mac, r_clr, r_lat, r_wall, r_valid, r_order_bad, r_tw_bad;
    bit   r_err;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Runs one transform; counts are taken once per enabled edge, from outputs seen just before it.
    task automatic run_xfer(input vec_t v);
        int cur_k, nidx, stall_left, act, wall, exp_k;
        bit act_next;
        r_res = 0; r_mac = 0; r_clr = 0; r_lat = -1; r_wall = -1; r_valid = 0;
        r_order_bad = 0; r_tw_bad = 0; r_err = 1'b0;
        cur_k = -1; nidx = 0; stall_left = v.stall_len; act = 0; wall = 0; exp_k = 0;
        @(negedge clk);
        sample_num = AW'(v.n); start = 1'b1; ce = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (r_lat < 0 && wall < 4000) begin
            if (done) begin
                r_lat  = act;
                r_wall = wall;
                r_err  = err;
            end else begin
                act_next = v.ce_tog ? ~ce : 1'b1;
                ce = act_next;
                res_ready = 1'b1;
                if (ce) begin
                    if (res_valid && res_k == AW'(v.stall_bin) && stall_left > 0) begin
                        res_ready = 1'b0;
                        stall_left--;
                    end
                    if (mac_clear) begin
                        r_clr++;
                        cur_k++;
                        nidx = 0;
                    end
                    if (mac_en) begin
                        r_mac++;
                        if (v.n == 0)
                            r_tw_bad++;
                        else if (sample_adr != AW'(nidx) || twiddle_adr != AW'((nidx * cur_k) % v.n))
                            r_tw_bad++;
                        if (v.n == 8 && cur_k == 3 && nidx < 8)
                            tw_k3[nidx] = int'(twiddle_adr);
                        nidx++;
                    end
                    if (res_valid) begin
                        r_valid++;
                        if (res_ready) begin
                            r_res++;
                            if (res_k != AW'(exp_k)) r_order_bad++;
                            exp_k++;
                        end
                    end
                    act++;
                end
                @(posedge clk);
                wall++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int exp_tw[8];
        int seen, macs, clrs, lat;
        bit got;

`ifdef DFT_SEQ_HALF_SPECTRUM_EN
        vt[0] = '{8, -1, 0, 1'b0, 5, 40, 5, 66, 5, 1'b0};
        vt[1] = '{4,  1, 5, 1'b0, 3, 12, 3, 33, 8, 1'b0};
        vt[2] = '{4, -1, 0, 1'b1, 3, 12, 3, 28, 3, 1'b0};
        vt[3] = '{0, -1, 0, 1'b0, 0,  0, 0,  1, 0, 1'b1};
        vt[4] = '{1, -1, 0, 1'b0, 1,  1, 1,  7, 1, 1'b0};
        vt[5] = '{3, -1, 0, 1'b0, 2,  6, 2, 17, 2, 1'b0};
`else
        vt[0] = '{8, -1, 0, 1'b0, 8, 64, 8, 105, 8, 1'b0};
        vt[1] = '{4,  1, 5, 1'b0, 4, 16, 4,  42, 9, 1'b0};
        vt[2] = '{4, -1, 0, 1'b1, 4, 16, 4,  37, 4, 1'b0};
        vt[3] = '{0, -1, 0, 1'b0, 0,  0, 0,   1, 0, 1'b1};
        vt[4] = '{1, -1, 0, 1'b0, 1,  1, 1,   7, 1, 1'b0};
        vt[5] = '{3, -1, 0, 1'b0, 3,  9, 3,  25, 3, 1'b0};
`endif
        exp_tw = '{0, 3, 6, 1, 4, 7, 2, 5};
        for (int i = 0; i < 8; i++) tw_k3[i] = -1;

        nrst = 1'b0; ce = 1'b0; start = 1'b0; res_ready = 1'b0; sample_num = '0;
        #1;
        check("reset_ctrl", int'({busy, done, err, mac_clear, mac_en, res_valid}), 0);
        check("reset_adr", int'(sample_adr) + int'(twiddle_adr) + int'(res_k), 0);
        #20;
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vt[i]);
            check($sformatf("v%0d_results", i), r_res, vt[i].exp_res);
            check($sformatf("v%0d_mac_en", i), r_mac, vt[i].exp_mac);
            check($sformatf("v%0d_mac_clear", i), r_clr, vt[i].exp_clr);
            check($sformatf("v%0d_latency", i), r_lat, vt[i].exp_lat);
            check($sformatf("v%0d_wall", i), r_wall, vt[i].ce_tog ? 2 * vt[i].exp_lat : vt[i].exp_lat);
            check($sformatf("v%0d_valid_cycles", i), r_valid, vt[i].exp_valid);
            check($sformatf("v%0d_err", i), int'(r_err), int'(vt[i].exp_err));
            check($sformatf("v%0d_res_k_order", i), r_order_bad, 0);
            check($sformatf("v%0d_addr_seq", i), r_tw_bad, 0);
            ce = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), int'({done, busy}), 0);
            check($sformatf("v%0d_err_sticky", i), int'(err), int'(vt[i].exp_err));
        end

        for (int i = 0; i < 8; i++)
            check($sformatf("k3_twiddle[%0d]", i), tw_k3[i], exp_tw[i]);

        // start held high while busy with a different length must not restart or relatch
        @(negedge clk);
        ce = 1'b1; res_ready = 1'b1; sample_num = AW'(2); start = 1'b1;
        @(posedge clk);
        macs = 0; clrs = 0; lat = -1;
        for (int c = 1; c <= 200 && lat < 0; c++) begin
            @(negedge clk);
            if (done) lat = c - 1;
            sample_num = AW'(5);
            start = (c <= 8);
            if (mac_en) macs++;
            if (mac_clear) clrs++;
            @(posedge clk);
        end
        start = 1'b0;
        check("busy_start_latency", lat, 15);
        check("busy_start_mac_en", macs, 4);
        check("busy_start_clears", clrs, 2);
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        sample_num = AW'(8); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (mac_en && sample_adr == AW'(3)) got = 1'b1;
            else @(negedge clk);
        end
        check("midrun_reached", int'(got), 1);
        #2 nrst = 1'b0;
        #1;
        check("midrun_reset_ctrl", int'({busy, done, err, mac_clear, mac_en, res_valid}), 0);
        check("midrun_reset_adr", int'(sample_adr) + int'(twiddle_adr) + int'(res_k), 0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy || mac_en || mac_clear || res_valid) seen++;
        end
        check("post_reset_quiet", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
